// File: rtl/fifo_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_arbiter_if
//   Bundles the FIFO read port and the consumer side of the read arbiter.
//   master : environment side (consumers + FIFO) -- drives req/rempty/rdata
//   slave  : arbiter side                        -- drives rinc/gnt/dout/dout_vld/busy
// Signals
//   req      [N_REQ]  consumer requests (level)
//   rempty            FIFO empty flag, rclk domain
//   rdata    [DSIZE]  FIFO word at the current read address
//   rinc              pop strobe to the FIFO
//   gnt      [N_REQ]  one-hot current grant, zero when idle
//   dout     [DSIZE]  last popped word
//   dout_vld [N_REQ]  one-hot valid for dout, per consumer
//   busy              arbiter is inside a burst
// ---------------------------------------------------------------------------
interface fifo_rd_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DSIZE = 8
);
  logic [N_REQ-1:0] req;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [N_REQ-1:0] gnt;
  logic [DSIZE-1:0] dout;
  logic [N_REQ-1:0] dout_vld;
  logic             busy;

  modport master (
    output req, rempty, rdata,
    input  rinc, gnt, dout, dout_vld, busy
  );

  modport slave (
    input  req, rempty, rdata,
    output rinc, gnt, dout, dout_vld, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rd_arbiter
//   Shares one async-FIFO read port among N_REQ consumers in the rclk domain.
//   Round-robin grant with bursts of at most MAX_BURST pops; one idle cycle
//   is spent arbitrating between grants. The popped word is registered and
//   presented to the granted consumer with a one-hot valid one cycle after
//   the pop strobe.
// Ports
//   rclk    read-domain clock
//   rrst_n  asynchronous active-low reset
//   bus     fifo_rd_arbiter_if.slave (req, rempty, rdata in;
//           rinc, gnt, dout, dout_vld, busy out)
// ---------------------------------------------------------------------------
module fifo_rd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input logic             rclk,
  input logic             rrst_n,
  fifo_rd_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]       state;
  logic [N_REQ-1:0] gnt_q;
  logic [IW-1:0]    last_gnt;
  logic [CW-1:0]    burst_cnt;
  logic [DSIZE-1:0] dout_p1;
  logic [N_REQ-1:0] vld_p1;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    cand_idx;
  int               cand;
  logic             req_g;
  logic             pop;
  logic             last_word;

  // Search starts just after the previous winner so the last served
  // consumer gets lowest priority; it can still win if it is alone.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_gnt) + k) % N_REQ;
      cand_idx = IW'(cand);
      if (!pick_vld && bus.req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // gnt_q is one-hot, so masking req with it selects req[g] without a mux.
  assign req_g     = |(bus.req & gnt_q);
  assign pop       = (state == BURST) && req_g && !bus.rempty;
  assign last_word = (burst_cnt == CW'(MAX_BURST - 1));

  assign bus.rinc     = pop;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = (state == BURST);
  assign bus.dout     = dout_p1;
  assign bus.dout_vld = vld_p1;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= IDLE;
      gnt_q     <= '0;
      last_gnt  <= IW'(N_REQ - 1);
      burst_cnt <= '0;
      dout_p1   <= '0;
      vld_p1    <= '0;
    end else begin
      // Stage p1: register the popped word and tag it for the granted consumer
      vld_p1 <= pop ? gnt_q : '0;
      if (pop) dout_p1 <= bus.rdata;

      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= BURST;
            gnt_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            last_gnt  <= pick_idx;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          // A dropped request ends the burst even if the FIFO just refilled;
          // an empty FIFO with the request still up simply holds the grant.
          if (!req_g || (pop && last_word)) begin
            state     <= IDLE;
            gnt_q     <= '0;
            burst_cnt <= '0;
          end else if (pop) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_arbiter
//   Drives fifo_rd_arbiter through a FIFO model and a data scoreboard.
//   Words pushed into the FIFO are also queued as expected output; each
//   dout_vld pops and compares one expected word. Scenario tasks check
//   grant order, burst lengths, stalls, request drop, reset and fairness.
// ---------------------------------------------------------------------------
module tb_fifo_rd_arbiter;

  localparam int N_REQ     = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;
  localparam int BOUND     = (N_REQ - 1) * (MAX_BURST + 1) + 1;

  logic rclk = 1'b0;
  logic rrst_n;

  fifo_rd_arbiter_if #(.N_REQ(N_REQ), .DSIZE(DSIZE)) bus ();

  fifo_rd_arbiter #(
    .N_REQ(N_REQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)
  ) dut (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .bus   (bus)
  );

  always #5 rclk = ~rclk;

  int checks   = 0;
  int failures = 0;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_data[$];
  logic [N_REQ-1:0] gnt_log[$];
  int               burst_log[$];
  int               idle_log[$];
  int               cur_pops;
  int               idle_run;
  logic [N_REQ-1:0] gnt_prev;
  logic [N_REQ-1:0] last_vld;
  bit               fair_en;
  int               wait_cnt[N_REQ];

  logic             rinc_s, rempty_s, stalled;
  logic [N_REQ-1:0] gnt_s, req_s, exp_vld;
  logic [DSIZE-1:0] exp_v;

  task automatic push_word(input logic [DSIZE-1:0] v);
    fifo_q.push_back(v);
    exp_data.push_back(v);
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    burst_log.delete();
    idle_log.delete();
  endtask

  // Monitor + FIFO model: sample just before the edge, check just after.
  initial begin
    bus.rempty = 1'b1;
    bus.rdata  = '0;
    cur_pops = 0; idle_run = 0; gnt_prev = '0; last_vld = '0; fair_en = 0;
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    forever begin
      @(posedge rclk);
      rinc_s   = bus.rinc;
      rempty_s = bus.rempty;
      gnt_s    = bus.gnt;
      req_s    = bus.req;
      stalled  = (|(gnt_s & req_s)) && rempty_s;
      for (int i = 0; i < N_REQ; i++) begin
        if (!rrst_n || !req_s[i] || gnt_s[i]) wait_cnt[i] = 0;
        else if (!stalled) wait_cnt[i]++;
      end
      #1;
      checks++;
      if (rinc_s && rempty_s) begin
        failures++; $display("FAIL pop_while_empty rinc=1 rempty=1 required rinc=0");
      end
      exp_vld = rinc_s ? gnt_s : '0;
      checks++;
      if (bus.dout_vld !== exp_vld) begin
        failures++; $display("FAIL dout_vld got=%b required=%b", bus.dout_vld, exp_vld);
      end
      if (rinc_s) begin
        checks++;
        if (exp_data.size() == 0) begin
          failures++; $display("FAIL dout_extra got=%h required=no word", bus.dout);
        end else begin
          exp_v = exp_data.pop_front();
          if (bus.dout !== exp_v) begin
            failures++; $display("FAIL dout_data got=%h required=%h", bus.dout, exp_v);
          end
        end
      end
      checks++;
      if ($countones(bus.gnt) > 1) begin
        failures++; $display("FAIL gnt_onehot got=%b required=onehot or zero", bus.gnt);
      end
      checks++;
      if (bus.busy !== (bus.gnt != '0)) begin
        failures++; $display("FAIL busy got=%b required=%b", bus.busy, (bus.gnt != '0));
      end
      if (gnt_prev != '0 && bus.gnt != '0) begin
        checks++;
        if (bus.gnt !== gnt_prev) begin
          failures++; $display("FAIL gnt_switch got=%b required=%b", bus.gnt, gnt_prev);
        end
      end
      if (fair_en) begin
        for (int i = 0; i < N_REQ; i++) begin
          checks++;
          if (wait_cnt[i] > BOUND) begin
            failures++; $display("FAIL starvation req=%0d wait=%0d required<=%0d", i, wait_cnt[i], BOUND);
          end
        end
      end
      if (bus.dout_vld != '0) begin
        cur_pops++;
        last_vld = bus.dout_vld;
      end
      if (gnt_prev != '0 && bus.gnt == '0) begin
        checks++;
        if (cur_pops > MAX_BURST) begin
          failures++; $display("FAIL burst_len got=%0d required<=%0d", cur_pops, MAX_BURST);
        end
        burst_log.push_back(cur_pops);
        cur_pops = 0;
      end
      if (gnt_prev == '0 && bus.gnt != '0) begin
        gnt_log.push_back(bus.gnt);
        idle_log.push_back(idle_run);
      end
      idle_run = (bus.gnt == '0) ? idle_run + 1 : 0;
      gnt_prev = bus.gnt;
      if (rinc_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
      bus.rempty = (fifo_q.size() == 0);
      bus.rdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  task automatic test_reset();
    rrst_n = 1'b0; bus.req = '0;
    repeat (3) @(negedge rclk);
    checks++; if (bus.gnt !== '0) begin failures++; $display("FAIL rst_gnt got=%b required=0", bus.gnt); end
    checks++; if (bus.dout_vld !== '0) begin failures++; $display("FAIL rst_vld got=%b required=0", bus.dout_vld); end
    checks++; if (bus.dout !== '0) begin failures++; $display("FAIL rst_dout got=%h required=0", bus.dout); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b required=0", bus.busy); end
    checks++; if (bus.rinc !== 1'b0) begin failures++; $display("FAIL rst_rinc got=%b required=0", bus.rinc); end
    rrst_n = 1'b1;
    repeat (2) @(negedge rclk);
    checks++; if (bus.gnt !== '0) begin failures++; $display("FAIL idle_gnt got=%b required=0", bus.gnt); end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] exp_g[3];
    exp_g = '{4'b0001, 4'b0010, 4'b0100};
    clear_logs();
    for (int i = 0; i < 12; i++) push_word(DSIZE'(8'h10 + i));
    bus.req = 4'b1111;
    for (int c = 0; c < 80 && burst_log.size() < 3; c++) @(negedge rclk);
    bus.req = '0;
    repeat (3) @(negedge rclk);
    checks++;
    if (burst_log.size() != 3 || gnt_log.size() != 3) begin
      failures++; $display("FAIL rr_count bursts=%0d grants=%0d required=3", burst_log.size(), gnt_log.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (gnt_log[k] !== exp_g[k]) begin failures++; $display("FAIL rr_gnt%0d got=%b required=%b", k, gnt_log[k], exp_g[k]); end
        checks++; if (burst_log[k] != 4) begin failures++; $display("FAIL rr_len%0d got=%0d required=4", k, burst_log[k]); end
      end
      for (int k = 1; k < 3; k++) begin
        checks++; if (idle_log[k] != 1) begin failures++; $display("FAIL rr_idle%0d got=%0d required=1", k, idle_log[k]); end
      end
    end
    checks++; if (exp_data.size() != 0) begin failures++; $display("FAIL rr_drain left=%0d required=0", exp_data.size()); end
  endtask

  task automatic test_single_stall();
    clear_logs();
    for (int i = 0; i < 10; i++) push_word(DSIZE'(8'h40 + i));
    bus.req = 4'b0100;
    for (int c = 0; c < 60 && (burst_log.size() < 2 || cur_pops < 2 || fifo_q.size() != 0); c++) @(negedge rclk);
    repeat (3) @(negedge rclk);
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL stall_gnt got=%b required=0100", bus.gnt); end
    checks++; if (bus.rinc !== 1'b0) begin failures++; $display("FAIL stall_rinc got=%b required=0", bus.rinc); end
    checks++; if (cur_pops != 2) begin failures++; $display("FAIL stall_pops got=%0d required=2", cur_pops); end
    checks++;
    if (burst_log.size() != 2 || gnt_log.size() != 3) begin
      failures++; $display("FAIL single_count bursts=%0d grants=%0d required=2,3", burst_log.size(), gnt_log.size());
    end else begin
      checks++; if (burst_log[0] != 4 || burst_log[1] != 4) begin failures++; $display("FAIL single_len got=%0d,%0d required=4,4", burst_log[0], burst_log[1]); end
      checks++; if (gnt_log[0] !== 4'b0100 || gnt_log[1] !== 4'b0100 || gnt_log[2] !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b,%b,%b required=0100", gnt_log[0], gnt_log[1], gnt_log[2]); end
    end
    push_word(8'hA0);
    for (int c = 0; c < 10 && exp_data.size() != 0; c++) @(negedge rclk);
    checks++; if (cur_pops != 3) begin failures++; $display("FAIL resume_pops got=%0d required=3", cur_pops); end
    checks++; if (last_vld !== 4'b0100) begin failures++; $display("FAIL resume_vld got=%b required=0100", last_vld); end
    bus.req = '0;
    repeat (3) @(negedge rclk);
    checks++; if (bus.gnt !== '0) begin failures++; $display("FAIL single_end got=%b required=0", bus.gnt); end
  endtask

  task automatic test_drop_req();
    clear_logs();
    for (int i = 0; i < 6; i++) push_word(DSIZE'(8'h60 + i));
    bus.req = 4'b0010;
    for (int c = 0; c < 20 && cur_pops < 2; c++) @(negedge rclk);
    bus.req = 4'b1001;
    #1;
    checks++; if (bus.rinc !== 1'b0) begin failures++; $display("FAIL drop_rinc got=%b required=0", bus.rinc); end
    for (int c = 0; c < 20 && burst_log.size() < 2; c++) @(negedge rclk);
    bus.req = '0;
    repeat (3) @(negedge rclk);
    checks++;
    if (burst_log.size() != 2 || gnt_log.size() != 2) begin
      failures++; $display("FAIL drop_count bursts=%0d grants=%0d required=2", burst_log.size(), gnt_log.size());
    end else begin
      checks++; if (gnt_log[0] !== 4'b0010) begin failures++; $display("FAIL drop_gnt0 got=%b required=0010", gnt_log[0]); end
      checks++; if (burst_log[0] != 2) begin failures++; $display("FAIL drop_len got=%0d required=2", burst_log[0]); end
      checks++; if (gnt_log[1] !== 4'b1000) begin failures++; $display("FAIL drop_next got=%b required=1000", gnt_log[1]); end
      checks++; if (idle_log[1] != 1) begin failures++; $display("FAIL drop_idle got=%0d required=1", idle_log[1]); end
    end
    checks++; if (exp_data.size() != 0) begin failures++; $display("FAIL drop_drain left=%0d required=0", exp_data.size()); end
  endtask

  task automatic test_empty_start();
    clear_logs();
    bus.req = 4'b0011;
    repeat (4) @(negedge rclk);
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL empty_gnt got=%b required=0001", bus.gnt); end
    checks++; if (bus.rinc !== 1'b0) begin failures++; $display("FAIL empty_rinc got=%b required=0", bus.rinc); end
    checks++; if (bus.dout_vld !== '0) begin failures++; $display("FAIL empty_vld got=%b required=0", bus.dout_vld); end
    push_word(8'hA5);
    for (int c = 0; c < 10 && exp_data.size() != 0; c++) @(negedge rclk);
    checks++; if (last_vld !== 4'b0001) begin failures++; $display("FAIL empty_first got=%b required=0001", last_vld); end
    checks++; if (bus.dout !== 8'hA5) begin failures++; $display("FAIL empty_dout got=%h required=a5", bus.dout); end
    bus.req = '0;
    repeat (3) @(negedge rclk);
  endtask

  task automatic test_reset_mid_burst();
    clear_logs();
    for (int i = 0; i < 6; i++) push_word(DSIZE'(8'h70 + i));
    bus.req = 4'b0010;
    for (int c = 0; c < 20 && cur_pops < 2; c++) @(negedge rclk);
    checks++; if (bus.rinc !== 1'b1) begin failures++; $display("FAIL mid_pre_rinc got=%b required=1", bus.rinc); end
    rrst_n = 1'b0;
    #1;
    checks++; if (bus.gnt !== '0) begin failures++; $display("FAIL mid_gnt got=%b required=0", bus.gnt); end
    checks++; if (bus.dout_vld !== '0) begin failures++; $display("FAIL mid_vld got=%b required=0", bus.dout_vld); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b required=0", bus.busy); end
    checks++; if (bus.rinc !== 1'b0) begin failures++; $display("FAIL mid_rinc got=%b required=0", bus.rinc); end
    bus.req = 4'b1010;
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    for (int c = 0; c < 20 && burst_log.size() < 2; c++) @(negedge rclk);
    bus.req = '0;
    repeat (3) @(negedge rclk);
    checks++;
    if (gnt_log.size() != 2 || burst_log.size() != 2) begin
      failures++; $display("FAIL mid_count grants=%0d bursts=%0d required=2", gnt_log.size(), burst_log.size());
    end else begin
      checks++; if (gnt_log[1] !== 4'b0010) begin failures++; $display("FAIL mid_regrant got=%b required=0010", gnt_log[1]); end
      checks++; if (burst_log[1] != 4) begin failures++; $display("FAIL mid_len got=%0d required=4", burst_log[1]); end
    end
    checks++; if (exp_data.size() != 0) begin failures++; $display("FAIL mid_drain left=%0d required=0", exp_data.size()); end
  endtask

  task automatic test_random();
    clear_logs();
    fair_en = 1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge rclk);
      bus.req = N_REQ'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) push_word(DSIZE'($urandom));
    end
    fair_en = 0;
    bus.req = '0;
    repeat (4) @(negedge rclk);
    checks++; if (burst_log.size() < 100) begin failures++; $display("FAIL rand_activity bursts=%0d required>=100", burst_log.size()); end
  endtask

  initial begin
    rrst_n  = 1'b0;
    bus.req = '0;
    test_reset();
    test_round_robin();
    test_single_stall();
    test_drop_req();
    test_empty_start();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
